data_memory_lsu: RTL and testbench
==================================

# data_memory_lsu

Byte-addressed, parametrised data memory with a valid/ready request port, RISC-V load/store sizing (byte/half/word, signed/unsigned loads), configurable wait states, and fault reporting for misaligned, out-of-range or illegal-size accesses. It sits in the MEM stage of the pipeline core. It replaces the word-only, single-cycle data memory, so the stage can model slower memories and real LSU behaviour. One request is in flight at a time.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; must be ≥ 2.
- WAIT_STATES, 0: extra cycles inserted before the access edge; 0..15.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block accepts a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  output  1  one-cycle pulse: response fields valid.
- rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and faults.
- rsp_fault  output  1  request was rejected; no memory side effect.

## Operation
- Reset behaviour:
  - The FSM goes to IDLE.
  - req_ready=0 while rst is high.
  - rsp_valid=0, rsp_rdata=0, rsp_fault=0, wait counter=0.
  - Memory contents are not reset.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: req_ready=1 (when rst=0). On req_valid&&req_ready, capture write, funct3, addr and wdata; load cnt=WAIT_STATES; go to BUSY.
  - BUSY: req_ready=0. If cnt≠0, decrement cnt. If cnt=0, perform the access and register the response fields, then go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle; go to IDLE. There is no response backpressure.
- Fault conditions, evaluated on the captured request:
  - funct3 illegal for the direction: loads accept {000,001,010,100,101}; stores accept {000,001,010}.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠00.
  - addr[31:2] ≥ DEPTH_WORDS.
- On fault:
  - rsp_fault=1 and rsp_rdata=0.
  - No write occurs.
  - Latency is identical to a good access.
- Load rules (word = mem[addr[31:2]]):
  - The byte is selected by addr[1:0]; the half is selected by addr[1] (bits [15:0] or [31:16]).
  - LB and LH sign-extend; LBU and LHU zero-extend; LW returns the word unchanged.
- Store rules:
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Unwritten lanes keep their value.
- rsp_rdata and rsp_fault hold their values after the pulse until the next response overwrites them.

## Timing
- Request accepted at edge k: the access (write commit / read sample) happens at edge k+1+WAIT_STATES, and rsp_valid is high in the following cycle.
- With WAIT_STATES=0, rsp_valid is seen 2 cycles after acceptance.
- The earliest next acceptance is at edge k+3+WAIT_STATES. Peak throughput is one request per WAIT_STATES+3 cycles.
- Request inputs are sampled only at the acceptance edge. Changes after acceptance have no effect.
- A load and a store to the same address are serialised. A load issued after a store's response returns the new data.
- Reset asserted in BUSY before the access edge: no write occurs and no response is produced.
- Reset asserted in RESP: rsp_valid drops immediately (asynchronously).
- req_valid held high across reset is accepted at the first edge where rst=0 and the FSM is in IDLE.

## Test plan
- WAIT_STATES=0: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → rsp_rdata=0xDEADBEEF, rsp_fault=0; rsp_valid exactly 2 cycles after each acceptance; req_ready low for 2 cycles after each acceptance.
- Sub-word loads of word 0x80F17F01 at 0x20:
  - LB 0x23 → 0xFFFFFF80; LBU 0x23 → 0x00000080.
  - LH 0x22 → 0xFFFF80F1; LHU 0x20 → 0x00007F01.
- Sub-word stores with word 0x20 = 0x11223344: SB 0x21 data 0xAA, then SH 0x22 data 0xBEEF → LW 0x20 returns 0xBEEFAA44.
- Faults, each giving rsp_fault=1, rsp_rdata=0, memory unchanged (verify by a follow-up LW):
  - LW 0x22.
  - LH 0x21.
  - SW 0x1000 with DEPTH_WORDS=1024.
  - Load funct3=011.
  - Store funct3=100.
- WAIT_STATES=3: LW accepted at edge k → rsp_valid exactly in the cycle after edge k+4; req_valid held high continuously → acceptances spaced 6 cycles apart.
- WAIT_STATES=3: SW 0x40 data 0x12345678 to a word previously holding 0x0; assert rst for 1 cycle, 2 cycles after acceptance → no rsp_valid, LW 0x40 after reset returns 0x00000000; req_ready=0 during rst.

Source files
------------

// File: rtl/data_memory_lsu.sv
// ----------------------------------------------------------------------------
// data_memory_lsu
//
// Byte-addressed data memory for the MEM stage. It has a valid/ready request
// port, RISC-V load/store sizing, configurable wait states and fault
// reporting. Only one request is in flight at a time. The FSM walks
// IDLE -> BUSY -> RESP. A request is captured on acceptance. It waits
// WAIT_STATES cycles in BUSY and is then performed on a single access edge.
// The response pulses for exactly one cycle in RESP.
//
// Parameters
//   DEPTH_WORDS   number of 32-bit words (>= 2)
//   WAIT_STATES   extra BUSY cycles before the access edge (0..15)
//
// Ports
//   i_clk          clock, rising-edge
//   i_rst          asynchronous active-high reset
//   i_req_valid    request present
//   o_req_ready    block accepts a request this cycle
//   i_req_write    1 = store, 0 = load
//   i_req_funct3   RISC-V funct3 (size / signedness)
//   i_req_addr     byte address
//   i_req_wdata    right-aligned store data
//   o_rsp_valid    one-cycle response pulse
//   o_rsp_rdata    extended load result, 0 for stores and faults (held)
//   o_rsp_fault    request rejected, no side effect (held)
// ----------------------------------------------------------------------------
module data_memory_lsu #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_fault
);

    localparam int          AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic [3:0]    r_cnt;
    logic          r_write;
    logic [2:0]    r_funct3;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rsp_rdata;
    logic          r_rsp_fault;

    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_ready;
    logic          w_rsp_valid;
    logic          w_accept;
    logic          w_access;

    logic          w_load_f3_ok;
    logic          w_store_f3_ok;
    logic          w_f3_bad;
    logic          w_misalign;
    logic          w_out_of_range;
    logic          w_fault;
    logic          w_mem_we;

    logic [AW-1:0] w_index;
    logic [31:0]   w_rword;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load_data;
    logic [31:0]   w_wword;
    logic [3:0]    w_be;

    // The state register is the only thing the FSM remembers. Because the
    // reset is asynchronous, a response pulse in RESP drops as soon as reset
    // rises. An access pending in BUSY is abandoned.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The next state and the handshake outputs come from the current state.
    // Ready is gated by reset so that nothing looks acceptable while the
    // block is held in reset. The access strobe fires on the last BUSY cycle,
    // which is the edge where the memory is written or read.
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_rsp_valid  = 1'b0;
        w_access     = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = ~i_rst;
                if (i_req_valid && !i_rst) begin
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_access     = 1'b1;
                    w_next_state = RESP;
                end
            end
            RESP: begin
                w_rsp_valid  = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_accept    = i_req_valid & w_ready;
    assign o_req_ready = w_ready;
    assign o_rsp_valid = w_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_fault = r_rsp_fault;

    // Fault checks run on the captured request. Any illegal funct3 is
    // rejected before the alignment checks. The range check compares the
    // full word address, so high address bits cannot alias into the array.
    assign w_load_f3_ok   = (r_funct3 == 3'b000) || (r_funct3 == 3'b001) ||
                            (r_funct3 == 3'b010) || (r_funct3 == 3'b100) ||
                            (r_funct3 == 3'b101);
    assign w_store_f3_ok  = (r_funct3 == 3'b000) || (r_funct3 == 3'b001) ||
                            (r_funct3 == 3'b010);
    assign w_f3_bad       = r_write ? ~w_store_f3_ok : ~w_load_f3_ok;
    assign w_misalign     = ((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                            ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
    assign w_out_of_range = {2'b00, r_addr[31:2]} >= DEPTH_LIMIT;
    assign w_fault        = w_f3_bad | w_misalign | w_out_of_range;
    assign w_mem_we       = w_access & r_write & ~w_fault;

    assign w_index = r_addr[AW+1:2];
    assign w_rword = r_mem[w_index];

    // Load path: pick the byte or half lane from the addressed word, then
    // extend it according to funct3. Illegal encodings fall to zero, and the
    // fault flag marks them anyway.
    always_comb begin
        w_byte      = 8'h00;
        w_half      = r_addr[1] ? w_rword[31:16] : w_rword[15:0];
        w_load_data = 32'h0000_0000;
        case (r_addr[1:0])
            2'b00:   w_byte = w_rword[7:0];
            2'b01:   w_byte = w_rword[15:8];
            2'b10:   w_byte = w_rword[23:16];
            default: w_byte = w_rword[31:24];
        endcase
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_data = w_rword;
            3'b100:  w_load_data = {24'h000000, w_byte};
            3'b101:  w_load_data = {16'h0000, w_half};
            default: w_load_data = 32'h0000_0000;
        endcase
    end

    // Store path: replicate the right-aligned data across the word and
    // enable only the lanes that this size and address touch. The other
    // lanes keep their old contents.
    always_comb begin
        w_wword = r_wdata;
        w_be    = 4'b0000;
        case (r_funct3[1:0])
            2'b00: begin
                w_wword = {4{r_wdata[7:0]}};
                w_be    = 4'b0001 << r_addr[1:0];
            end
            2'b01: begin
                w_wword = {2{r_wdata[15:0]}};
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                w_wword = r_wdata;
                w_be    = 4'b1111;
            end
            default: begin
                w_be    = 4'b0000;
            end
        endcase
    end

    // Request capture, the wait-state counter and the response registers.
    // The inputs are sampled only on acceptance, so later changes on the port
    // are ignored. The response fields change only on the access edge and
    // hold until the next access.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr      <= 32'h0000_0000;
            r_wdata     <= 32'h0000_0000;
            r_rsp_rdata <= 32'h0000_0000;
            r_rsp_fault <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write  <= i_req_write;
                r_funct3 <= i_req_funct3;
                r_addr   <= i_req_addr;
                r_wdata  <= i_req_wdata;
                r_cnt    <= WAIT_LOAD;
            end else if ((r_state == BUSY) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                r_rsp_fault <= w_fault;
                r_rsp_rdata <= (w_fault || r_write) ? 32'h0000_0000 : w_load_data;
            end
        end
    end

    // The memory array has no reset, so its contents survive reset. The
    // write enable derives from the reset-cleared state register. A reset
    // during BUSY therefore cancels the pending store.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_index][8*b +: 8] <= w_wword[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_lsu.sv
// ----------------------------------------------------------------------------
// tb_data_memory_lsu
//
// Directed bench for data_memory_lsu. One instance runs with WAIT_STATES=0
// and another with WAIT_STATES=3. Inputs change on the falling edge and are
// sampled on the falling edge. Every expected value is a hand-computed
// constant.
// ----------------------------------------------------------------------------
module tb_data_memory_lsu;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic        clk = 1'b0;

    logic        rst0, reqValid0, reqReady0, reqWrite0, rspValid0, rspFault0;
    logic [2:0]  reqFunct3_0;
    logic [31:0] reqAddr0, reqWdata0, rspRdata0;

    logic        rst3, reqValid3, reqReady3, reqWrite3, rspValid3, rspFault3;
    logic [2:0]  reqFunct3_3;
    logic [31:0] reqAddr3, reqWdata3, rspRdata3;

    int          total = 0;
    int          bad   = 0;

    logic [31:0] gotRdata;
    logic        gotFault;
    int          gotLat;
    int          gotNotReady;
    logic        gotValidAfter;
    logic [31:0] gotRdataAfter;

    int          firstAcc;
    int          secondAcc;
    int          strayRsp;

    // Free-running clock shared by both instances.
    always #5 clk = ~clk;

    data_memory_lsu #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
        .i_clk        (clk),
        .i_rst        (rst0),
        .i_req_valid  (reqValid0),
        .o_req_ready  (reqReady0),
        .i_req_write  (reqWrite0),
        .i_req_funct3 (reqFunct3_0),
        .i_req_addr   (reqAddr0),
        .i_req_wdata  (reqWdata0),
        .o_rsp_valid  (rspValid0),
        .o_rsp_rdata  (rspRdata0),
        .o_rsp_fault  (rspFault0)
    );

    data_memory_lsu #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_dut3 (
        .i_clk        (clk),
        .i_rst        (rst3),
        .i_req_valid  (reqValid3),
        .o_req_ready  (reqReady3),
        .i_req_write  (reqWrite3),
        .i_req_funct3 (reqFunct3_3),
        .i_req_addr   (reqAddr3),
        .i_req_wdata  (reqWdata3),
        .o_rsp_valid  (rspValid3),
        .o_rsp_rdata  (rspRdata3),
        .o_rsp_fault  (rspFault3)
    );

    // One counted comparison with an immediate assertion.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives the request port of the selected instance.
    task automatic driveReq(input bit sel, input logic v, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d);
        if (sel) begin
            reqValid3 = v; reqWrite3 = wr; reqFunct3_3 = f3; reqAddr3 = a; reqWdata3 = d;
        end else begin
            reqValid0 = v; reqWrite0 = wr; reqFunct3_0 = f3; reqAddr0 = a; reqWdata0 = d;
        end
    endtask

    // Runs one full transaction on the selected instance. After acceptance,
    // the request lines are scrambled. The task records the latency in
    // falling edges, the number of not-ready samples, the response fields
    // and what the outputs show one cycle after the pulse.
    task automatic applyStimulus(input bit sel, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] d);
        int  guard;
        bit  seen;
        @(negedge clk);
        driveReq(sel, 1'b1, wr, f3, a, d);
        guard = 0;
        while (!(sel ? reqReady3 : reqReady0) && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        driveReq(sel, 1'b0, ~wr, 3'b111, 32'hFFFF_FFFF, ~d);
        gotLat      = 0;
        gotNotReady = 0;
        gotRdata    = 32'hBAD0_BAD0;
        gotFault    = 1'bx;
        seen        = 1'b0;
        for (int c = 1; c <= 30 && !seen; c++) begin
            @(negedge clk);
            if (!(sel ? reqReady3 : reqReady0)) gotNotReady++;
            if (sel ? rspValid3 : rspValid0) begin
                seen     = 1'b1;
                gotLat   = c;
                gotRdata = sel ? rspRdata3 : rspRdata0;
                gotFault = sel ? rspFault3 : rspFault0;
            end
        end
        @(negedge clk);
        if (!(sel ? reqReady3 : reqReady0)) gotNotReady++;
        gotValidAfter = sel ? rspValid3 : rspValid0;
        gotRdataAfter = sel ? rspRdata3 : rspRdata0;
    endtask

    // Linear directed sequence.
    initial begin
        rst0 = 1'b1;
        rst3 = 1'b1;
        driveReq(1'b0, 1'b0, 1'b0, F_W, 32'h0, 32'h0);
        driveReq(1'b1, 1'b0, 1'b0, F_W, 32'h0, 32'h0);
        repeat (2) @(negedge clk);

        checkOutput("rst_ready0",  32'(reqReady0), 32'd0);
        checkOutput("rst_ready3",  32'(reqReady3), 32'd0);
        checkOutput("rst_valid0",  32'(rspValid0), 32'd0);
        checkOutput("rst_rdata0",  rspRdata0, 32'h0);
        checkOutput("rst_fault0",  32'(rspFault0), 32'd0);
        rst0 = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);
        checkOutput("idle_ready0", 32'(reqReady0), 32'd1);

        $display("[TB] basic word store/load, zero wait states");
        applyStimulus(1'b0, 1'b1, F_W, 32'h10, 32'hDEAD_BEEF);
        checkOutput("sw10_fault",    32'(gotFault), 32'd0);
        checkOutput("sw10_rdata",    gotRdata, 32'h0);
        checkOutput("sw10_lat",      32'(gotLat), 32'd2);
        checkOutput("sw10_notready", 32'(gotNotReady), 32'd2);
        checkOutput("sw10_pulse",    32'(gotValidAfter), 32'd0);
        applyStimulus(1'b0, 1'b0, F_W, 32'h10, 32'h0);
        checkOutput("lw10_rdata",    gotRdata, 32'hDEAD_BEEF);
        checkOutput("lw10_fault",    32'(gotFault), 32'd0);
        checkOutput("lw10_lat",      32'(gotLat), 32'd2);
        checkOutput("lw10_notready", 32'(gotNotReady), 32'd2);
        checkOutput("lw10_hold",     gotRdataAfter, 32'hDEAD_BEEF);

        $display("[TB] sub-word loads");
        applyStimulus(1'b0, 1'b1, F_W, 32'h20, 32'h80F1_7F01);
        applyStimulus(1'b0, 1'b0, F_B, 32'h23, 32'h0);
        checkOutput("lb23",  gotRdata, 32'hFFFF_FF80);
        applyStimulus(1'b0, 1'b0, F_BU, 32'h23, 32'h0);
        checkOutput("lbu23", gotRdata, 32'h0000_0080);
        applyStimulus(1'b0, 1'b0, F_H, 32'h22, 32'h0);
        checkOutput("lh22",  gotRdata, 32'hFFFF_80F1);
        applyStimulus(1'b0, 1'b0, F_HU, 32'h20, 32'h0);
        checkOutput("lhu20", gotRdata, 32'h0000_7F01);
        applyStimulus(1'b0, 1'b0, F_B, 32'h20, 32'h0);
        checkOutput("lb20",  gotRdata, 32'h0000_0001);

        $display("[TB] sub-word stores");
        applyStimulus(1'b0, 1'b1, F_W, 32'h20, 32'h1122_3344);
        applyStimulus(1'b0, 1'b1, F_B, 32'h21, 32'h0000_00AA);
        applyStimulus(1'b0, 1'b1, F_H, 32'h22, 32'h0000_BEEF);
        applyStimulus(1'b0, 1'b0, F_W, 32'h20, 32'h0);
        checkOutput("merge20", gotRdata, 32'hBEEF_AA44);

        $display("[TB] top word boundary");
        applyStimulus(1'b0, 1'b1, F_W, 32'hFFC, 32'h0BAD_CAFE);
        checkOutput("swtop_fault", 32'(gotFault), 32'd0);
        applyStimulus(1'b0, 1'b0, F_W, 32'hFFC, 32'h0);
        checkOutput("lwtop_rdata", gotRdata, 32'h0BAD_CAFE);

        $display("[TB] faults");
        applyStimulus(1'b0, 1'b1, F_W, 32'h24, 32'hCAFE_F00D);
        applyStimulus(1'b0, 1'b1, F_W, 32'h0, 32'h55AA_55AA);
        applyStimulus(1'b0, 1'b0, F_W, 32'h22, 32'h0);
        checkOutput("lw22_fault", 32'(gotFault), 32'd1);
        checkOutput("lw22_rdata", gotRdata, 32'h0);
        checkOutput("lw22_lat",   32'(gotLat), 32'd2);
        applyStimulus(1'b0, 1'b0, F_H, 32'h21, 32'h0);
        checkOutput("lh21_fault", 32'(gotFault), 32'd1);
        checkOutput("lh21_rdata", gotRdata, 32'h0);
        applyStimulus(1'b0, 1'b1, F_W, 32'h1000, 32'hFFFF_FFFF);
        checkOutput("sw1000_fault", 32'(gotFault), 32'd1);
        checkOutput("sw1000_rdata", gotRdata, 32'h0);
        applyStimulus(1'b0, 1'b0, F_W, 32'h0, 32'h0);
        checkOutput("lw0_noalias", gotRdata, 32'h55AA_55AA);
        applyStimulus(1'b0, 1'b0, 3'b011, 32'h24, 32'h0);
        checkOutput("ld011_fault", 32'(gotFault), 32'd1);
        checkOutput("ld011_rdata", gotRdata, 32'h0);
        applyStimulus(1'b0, 1'b1, 3'b100, 32'h24, 32'h0);
        checkOutput("st100_fault", 32'(gotFault), 32'd1);
        applyStimulus(1'b0, 1'b1, F_H, 32'h23, 32'h0);
        checkOutput("sh23_fault",  32'(gotFault), 32'd1);
        applyStimulus(1'b0, 1'b0, F_W, 32'h24, 32'h0);
        checkOutput("lw24_intact", gotRdata, 32'hCAFE_F00D);
        checkOutput("lw24_fault",  32'(gotFault), 32'd0);

        $display("[TB] reset during response pulse");
        @(negedge clk);
        driveReq(1'b0, 1'b1, 1'b0, F_W, 32'h10, 32'h0);
        @(posedge clk);
        #1;
        driveReq(1'b0, 1'b0, 1'b0, F_W, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("resp_pulse_seen", 32'(rspValid0), 32'd1);
        rst0 = 1'b1;
        #1;
        checkOutput("resp_rst_valid", 32'(rspValid0), 32'd0);
        checkOutput("resp_rst_rdata", rspRdata0, 32'h0);
        @(negedge clk);
        rst0 = 1'b0;

        $display("[TB] three wait states");
        applyStimulus(1'b1, 1'b1, F_W, 32'h40, 32'h0);
        checkOutput("w3_sw_lat", 32'(gotLat), 32'd5);
        applyStimulus(1'b1, 1'b0, F_W, 32'h40, 32'h0);
        checkOutput("w3_lw_lat",      32'(gotLat), 32'd5);
        checkOutput("w3_lw_notready", 32'(gotNotReady), 32'd5);
        checkOutput("w3_lw_rdata",    gotRdata, 32'h0);

        @(negedge clk);
        driveReq(1'b1, 1'b1, 1'b0, F_W, 32'h40, 32'h0);
        firstAcc  = -1;
        secondAcc = -1;
        for (int c = 0; c < 30; c++) begin
            if (reqReady3 && reqValid3) begin
                if (firstAcc < 0) firstAcc = c;
                else if (secondAcc < 0) secondAcc = c;
            end
            @(negedge clk);
        end
        driveReq(1'b1, 1'b0, 1'b0, F_W, 32'h0, 32'h0);
        checkOutput("w3_b2b_spacing", 32'(secondAcc - firstAcc), 32'd6);
        repeat (10) @(negedge clk);

        $display("[TB] reset during busy");
        driveReq(1'b1, 1'b1, 1'b1, F_W, 32'h40, 32'h1234_5678);
        @(posedge clk);
        #1;
        driveReq(1'b1, 1'b0, 1'b0, F_W, 32'h0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst3 = 1'b1;
        #1;
        checkOutput("busy_rst_ready", 32'(reqReady3), 32'd0);
        @(negedge clk);
        checkOutput("busy_rst_ready_neg", 32'(reqReady3), 32'd0);
        rst3 = 1'b0;
        strayRsp = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rspValid3) strayRsp++;
        end
        checkOutput("busy_rst_no_rsp", 32'(strayRsp), 32'd0);
        applyStimulus(1'b1, 1'b0, F_W, 32'h40, 32'h0);
        checkOutput("busy_rst_no_write", gotRdata, 32'h0);
        checkOutput("busy_rst_lw_fault", 32'(gotFault), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
